// File: rtl/wb_module_bridge.sv
// Wishbone classic slave fronting the user-project module array: decodes a hit into
// module select / word offset / write strobe and returns the muxed read data with a one-cycle ack.
module wb_module_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] BASE_MASK = 32'hFFFF_0000,
  parameter int          MOD_LSB   = 8,
  parameter int          READ_WAIT = 2
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  output logic                 we_o,
  output logic [2:0]           addr_o,
  output logic [MOD_LSB-3:0]   reg_addr_o,
  output logic [3:0]           sel_o,
  output logic [31:0]          wdata_o,
  input  logic [31:0]          rdata_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] cnt_q;
  logic [3:0] cnt_d;
  logic       is_wr_q;
  logic       hit;
  logic       latch;
  logic       access_done;
  logic       rd_latch;
  logic       ack_d;
  logic       we_d;

  assign hit = wbs_cyc_i & wbs_stb_i &
               ((wbs_adr_i & BASE_MASK) == (BASE_ADDR & BASE_MASK));

  // A write leaves ACCESS after one cycle; a read once the wait counter has drained.
  assign access_done = is_wr_q || (cnt_q == 4'd0);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (hit) state_d = ACCESS;
      end
      ACCESS: begin
        if (!wbs_cyc_i)       state_d = IDLE;
        else if (access_done) state_d = ACK;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    latch    = 1'b0;
    we_d     = 1'b0;
    ack_d    = 1'b0;
    rd_latch = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (hit) begin
          latch = 1'b1;
          we_d  = wbs_we_i;
          cnt_d = 4'(READ_WAIT);
        end
      end
      ACCESS: begin
        if (wbs_cyc_i) begin
          ack_d    = access_done;
          rd_latch = access_done && !is_wr_q;
        end
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end
      default: begin
        cnt_d = cnt_q;
      end
    endcase
  end

  // Request fields hold their last value in IDLE so the modules never see them glitch.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q      <= '0;
      is_wr_q    <= 1'b0;
      wbs_ack_o  <= 1'b0;
      we_o       <= 1'b0;
      addr_o     <= '0;
      reg_addr_o <= '0;
      sel_o      <= '0;
      wdata_o    <= '0;
      wbs_dat_o  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      wbs_ack_o <= ack_d;
      we_o      <= we_d;
      if (latch) begin
        is_wr_q    <= wbs_we_i;
        addr_o     <= wbs_adr_i[MOD_LSB+2:MOD_LSB];
        reg_addr_o <= wbs_adr_i[MOD_LSB-1:2];
        sel_o      <= wbs_sel_i;
        wdata_o    <= wbs_dat_i;
      end
      if (rd_latch) wbs_dat_o <= rdata_i;
    end
  end

endmodule

// File: tb/tb_wb_module_bridge.sv
// Bench for wb_module_bridge: reset, table of directed transactions, abort and
// back-to-back sequences, then random transactions against a transaction-level model.
module tb_wb_module_bridge;
  localparam int RW = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we_i;
  logic [3:0]  sel_i;
  logic [31:0] adr_i, dat_i;
  logic        ack_o;
  logic [31:0] dat_o;
  logic        we_o;
  logic [2:0]  addr_o;
  logic [5:0]  reg_addr_o;
  logic [3:0]  sel_o;
  logic [31:0] wdata_o;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  wb_module_bridge #(.READ_WAIT(RW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we_i),
    .wbs_sel_i(sel_i), .wbs_adr_i(adr_i), .wbs_dat_i(dat_i), .wbs_ack_o(ack_o),
    .wbs_dat_o(dat_o), .we_o(we_o), .addr_o(addr_o), .reg_addr_o(reg_addr_o),
    .sel_o(sel_o), .wdata_o(wdata_o), .rdata_i(rdata)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Results of the most recent run_txn; cycle numbers count from the hit edge (T0).
  int          r_ack_at, r_we_cnt, r_we_at;
  logic [31:0] r_dat, r_wdata_at_we;
  logic [2:0]  r_addr_at_we;
  logic [5:0]  r_reg_at_we;
  logic [31:0] rd_val [0:15];

  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int max_cyc);
    r_ack_at = -1; r_we_cnt = 0; r_we_at = -1; r_dat = '0;
    r_wdata_at_we = '0; r_addr_at_we = '0; r_reg_at_we = '0;
    cyc = 1'b1; stb = 1'b1; we_i = we; adr_i = adr; dat_i = dat; sel_i = sel;
    for (int i = 0; i < max_cyc; i++) begin
      rdata = rd_val[i];
      tick();
      if (we_o) begin
        r_we_cnt++;
        r_we_at = i + 1;
        r_addr_at_we = addr_o; r_reg_at_we = reg_addr_o; r_wdata_at_we = wdata_o;
      end
      if (ack_o) begin
        r_ack_at = i + 1;
        r_dat = dat_o;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] rdata;
    int          exp_ack;
    logic [2:0]  exp_addr;
    logic [5:0]  exp_reg;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl [7];

  // Transaction-level model state for the random phase.
  logic [2:0]  m_addr;
  logic [5:0]  m_reg;
  logic [3:0]  m_sel;
  logic [31:0] m_wdata, m_dat;
  logic        m_valid;

  initial begin
    int first_ack, gap_ack, gap_we;
    logic [2:0] gap_addr;

    tbl[0] = '{1'b1, 32'h3000_0204, 32'hDEAD_BEEF, 4'hF, 32'h0,         2,  3'd2, 6'd1,  32'h0};
    tbl[1] = '{1'b0, 32'h3000_0300, 32'h0,         4'hF, 32'h1234_5678, 4,  3'd3, 6'd0,  32'h1234_5678};
    tbl[2] = '{1'b0, 32'h2000_0100, 32'h0,         4'hF, 32'hFFFF_FFFF, -1, 3'd3, 6'd0,  32'h1234_5678};
    tbl[3] = '{1'b1, 32'h3000_0500, 32'h0BAD_F00D, 4'h3, 32'h0,         2,  3'd5, 6'd0,  32'h1234_5678};
    tbl[4] = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 32'h0,         4,  3'd0, 6'd0,  32'h0};
    tbl[5] = '{1'b1, 32'h3001_0204, 32'h7777_7777, 4'hF, 32'h0,         -1, 3'd0, 6'd0,  32'h0};
    tbl[6] = '{1'b0, 32'h3000_07FC, 32'h0,         4'h5, 32'hA5A5_5A5A, 4,  3'd7, 6'd63, 32'hA5A5_5A5A};

    // Reset held with a live hit on the bus.
    rst = 1'b1; cyc = 1'b1; stb = 1'b1; we_i = 1'b1; sel_i = 4'hF;
    adr_i = 32'h3000_0204; dat_i = 32'h1111_1111; rdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_ack", 32'(ack_o), 32'h0);
      chk("rst_we", 32'(we_o), 32'h0);
      chk("rst_dat", dat_o, 32'h0);
      chk("rst_addr", 32'(addr_o), 32'h0);
    end
    rst = 1'b0;
    tick();
    chk("post_rst_we", 32'(we_o), 32'h1);
    chk("post_rst_ack_early", 32'(ack_o), 32'h0);
    tick();
    chk("post_rst_ack", 32'(ack_o), 32'h1);
    cyc = 1'b0; stb = 1'b0;
    tick();

    // Directed table.
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 16; i++) rd_val[i] = tbl[v].rdata;
      run_txn(tbl[v].we, tbl[v].adr, tbl[v].dat, tbl[v].sel, 10);
      chk($sformatf("tbl%0d_ack_lat", v), 32'(r_ack_at), 32'(tbl[v].exp_ack));
      chk($sformatf("tbl%0d_we_cnt", v), 32'(r_we_cnt),
          32'((tbl[v].we && tbl[v].exp_ack >= 0) ? 1 : 0));
      chk($sformatf("tbl%0d_addr", v), 32'(addr_o), 32'(tbl[v].exp_addr));
      chk($sformatf("tbl%0d_reg", v), 32'(reg_addr_o), 32'(tbl[v].exp_reg));
      chk($sformatf("tbl%0d_dat", v), dat_o, tbl[v].exp_dat);
      if (tbl[v].exp_ack >= 0) begin
        chk($sformatf("tbl%0d_sel", v), 32'(sel_o), 32'(tbl[v].sel));
        chk($sformatf("tbl%0d_wdata", v), wdata_o, tbl[v].dat);
        if (tbl[v].we) begin
          chk($sformatf("tbl%0d_we_at", v), 32'(r_we_at), 32'd1);
          chk($sformatf("tbl%0d_we_addr", v), 32'(r_addr_at_we), 32'(tbl[v].exp_addr));
          chk($sformatf("tbl%0d_we_wdata", v), r_wdata_at_we, tbl[v].dat);
        end else begin
          chk($sformatf("tbl%0d_ack_dat", v), r_dat, tbl[v].rdata);
        end
      end
      tick();
    end

    // Abort: read hit at T0, cyc low in T2, new write presented in T3.
    cyc = 1'b1; stb = 1'b1; we_i = 1'b0; adr_i = 32'h3000_0300; sel_i = 4'hF;
    rdata = 32'h9999_9999;
    tick();
    chk("abort_t1_ack", 32'(ack_o), 32'h0);
    tick();
    cyc = 1'b0; stb = 1'b0;
    tick();
    chk("abort_t3_ack", 32'(ack_o), 32'h0);
    for (int i = 0; i < 16; i++) rd_val[i] = 32'h9999_9999;
    run_txn(1'b1, 32'h3000_0408, 32'hC0DE_0001, 4'hF, 10);
    chk("abort_next_ack_lat", 32'(r_ack_at), 32'd2);
    chk("abort_next_we_cnt", 32'(r_we_cnt), 32'd1);
    chk("abort_dat_kept", dat_o, 32'hA5A5_5A5A);
    tick();

    // Back-to-back: stb stays high after the ack with a new request.
    cyc = 1'b1; stb = 1'b1; we_i = 1'b1; adr_i = 32'h3000_0204; dat_i = 32'h1357_9BDF; sel_i = 4'hF;
    first_ack = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ack_o) begin first_ack = i + 1; break; end
    end
    chk("b2b_first_ack", 32'(first_ack), 32'd2);
    adr_i = 32'h3000_0104; dat_i = 32'h55AA_55AA;
    gap_ack = -1; gap_we = -1; gap_addr = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (we_o) begin gap_we = i + 1; gap_addr = addr_o; end
      if (ack_o) begin gap_ack = i + 1; break; end
    end
    cyc = 1'b0; stb = 1'b0;
    chk("b2b_second_ack_gap", 32'(gap_ack), 32'd3);
    chk("b2b_second_we", 32'(gap_we), 32'd2);
    chk("b2b_second_addr", 32'(gap_addr), 32'd1);
    chk("b2b_second_reg", 32'(reg_addr_o), 32'd1);
    tick();

    // Random transactions against the model.
    m_valid = 1'b0; m_dat = 32'hA5A5_5A5A;
    m_addr = '0; m_reg = '0; m_sel = '0; m_wdata = '0;
    for (int t = 0; t < 40; t++) begin
      logic        we, hit;
      logic [31:0] adr, dat;
      logic [3:0]  sel;
      int          exp_ack;
      we  = 1'($urandom_range(0, 1));
      adr = {16'h3000, 16'($urandom)};
      if ($urandom_range(0, 4) == 0) adr[31:16] = 16'h3001 + 16'($urandom_range(0, 100));
      dat = $urandom;
      sel = 4'($urandom);
      for (int i = 0; i < 16; i++) rd_val[i] = $urandom;

      hit = ((adr & 32'hFFFF_0000) == 32'h3000_0000);
      exp_ack = !hit ? -1 : (we ? 2 : RW + 2);
      if (hit) begin
        m_valid = 1'b1;
        m_addr = 3'((adr >> 8) & 32'h7);
        m_reg = 6'((adr >> 2) & 32'h3F);
        m_sel = sel;
        m_wdata = dat;
        if (!we) m_dat = rd_val[RW + 1];
      end

      run_txn(we, adr, dat, sel, 10);
      chk($sformatf("rnd%0d_ack_lat", t), 32'(r_ack_at), 32'(exp_ack));
      chk($sformatf("rnd%0d_we_cnt", t), 32'(r_we_cnt), 32'((hit && we) ? 1 : 0));
      chk($sformatf("rnd%0d_dat", t), dat_o, m_dat);
      if (m_valid) begin
        chk($sformatf("rnd%0d_addr", t), 32'(addr_o), 32'(m_addr));
        chk($sformatf("rnd%0d_reg", t), 32'(reg_addr_o), 32'(m_reg));
        chk($sformatf("rnd%0d_sel", t), 32'(sel_o), 32'(m_sel));
        chk($sformatf("rnd%0d_wdata", t), wdata_o, m_wdata);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_module_bridge.md
Name: wb_module_bridge

Overview:
- Wishbone classic slave that fronts the user-project module array.
- Decodes a bus transaction into a module select, register offset, write data and a single-cycle write strobe, which the module-select/read-mux block consumes.
- Captures that block's muxed read data and returns it with a one-cycle acknowledge.
- Sits between the Caravel Wishbone port and the module-select block; it is the initiator side of that interface.

Parameters:
- BASE_ADDR, 32'h3000_0000, base of the user address window.
- BASE_MASK, 32'hFFFF_0000, bits compared against BASE_ADDR for a hit.
- MOD_LSB, 8, lowest address bit of the 3-bit module select field (bits MOD_LSB+2:MOD_LSB).
- READ_WAIT, 2, extra wait cycles before read data is sampled (0..15).

Ports:
- wb_clk_i  input  1  clock
- wb_rst_i  input  1  synchronous active-high reset
- wbs_cyc_i  input  1  bus cycle valid
- wbs_stb_i  input  1  strobe
- wbs_we_i  input  1  1=write, 0=read
- wbs_sel_i  input  4  byte lane selects
- wbs_adr_i  input  32  byte address
- wbs_dat_i  input  32  write data
- wbs_ack_o  output  1  acknowledge, one-cycle pulse
- wbs_dat_o  output  32  read data, valid while ack high
- we_o  output  1  write strobe to module-select block
- addr_o  output  3  module select (1..4 valid; others select nothing)
- reg_addr_o  output  MOD_LSB-2  word offset within module (adr[MOD_LSB-1:2])
- sel_o  output  4  registered wbs_sel_i
- wdata_o  output  32  registered wbs_dat_i
- rdata_i  input  32  muxed read data returned by module-select block

Behaviour:
- All outputs are registered. Reset (wb_rst_i high at a rising edge) forces state IDLE, wait counter 0, and every output to 0. A reset mid-transaction abandons it with no ack.
- Hit condition: cyc & stb & ((adr & BASE_MASK) == (BASE_ADDR & BASE_MASK)).
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - On hit at edge T0, latch addr_o=adr[MOD_LSB+2:MOD_LSB], reg_addr_o, sel_o, wdata_o and the we flag, then go to ACCESS.
  - A miss stays in IDLE, never acks, and outputs do not change.
- ACCESS, write: we_o=1 for exactly the one cycle T1, then go to ACK. we_o is 0 in every other state.
- ACCESS, read:
  - Stays READ_WAIT+1 cycles; the counter counts down from READ_WAIT.
  - On the last ACCESS edge, latch wbs_dat_o <= rdata_i and go to ACK.
- ACK:
  - wbs_ack_o=1 for exactly one cycle, then go to IDLE.
  - wbs_dat_o holds its value until the next read latch; it is not cleared after ack.
- Latency from the first hit cycle to the ack cycle: write 2 cycles; read READ_WAIT+2 cycles.
- Out-of-range select (0 or 5..7): the transaction completes normally and is acked. The downstream block drops the write and returns 0 on reads; the bridge does not special-case it.
- Abort: if cyc_i falls while in ACCESS or ACK, the next state is IDLE and ack is suppressed from the following cycle. A write strobe already issued is not retracted.
- Back-to-back: a new hit is only accepted in IDLE, so there is a minimum of one idle cycle between acks. stb still high in the cycle after ack starts a new transaction.
- addr_o, reg_addr_o, sel_o and wdata_o hold their last values in IDLE, so no glitching reaches the modules.

Test Plan:
- Reset: assert wb_rst_i 2 cycles with stb/cyc high and a hit address -> ack_o=0, we_o=0, dat_o=0, addr_o=0 throughout; first edge after release starts ACCESS.
- Write hit: adr=0x3000_0204, dat=0xDEAD_BEEF, sel=0xF, we=1 ->
  - cycle T1: we_o=1, addr_o=2, reg_addr_o=1, wdata_o=0xDEADBEEF;
  - cycle T2: ack_o=1;
  - we_o asserted exactly one cycle.
- Read with READ_WAIT=2: adr=0x3000_0300, rdata_i=0x1234_5678 -> ack at T4, dat_o=0x12345678, we_o never high, addr_o=3.
- Miss: adr=0x2000_0100 with stb/cyc held 10 cycles -> no ack, no we_o, outputs unchanged.
- Out-of-range select: write to adr=0x3000_0500 (select 5) -> acked at T2, we_o pulses with addr_o=5; read from 0x3000_0000 with rdata_i=0 -> dat_o=0.
- Abort: read issued, cyc dropped at T2 with READ_WAIT=2 -> no ack. FSM is in IDLE by T3 and the next transaction completes with normal latency.
